neuron_mac_acc: RTL
===================

# neuron_mac_acc

Serial multiply-accumulate stage for one neuron of the 8-neuron serial grid. It takes one signed 6-bit activation/weight pair per accepted beat and adds the product into an 18-bit signed saturating accumulator seeded with a bias. After N_INPUTS beats it presents the result split as `dout_msb`/`dout_lsb`, which is exactly the operand format of the downstream ReLU stage.

## Interface
- `N_INPUTS`, default 8: beats accumulated per run; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `bias` input 12: signed bias, sampled with `start` and sign-extended to 18 bits.
- `in_valid` input 1: `x`/`w` pair valid.
- `in_ready` output 1: stage accepts a pair this cycle.
- `x` input 6: signed activation.
- `w` input 6: signed weight.
- `dout_valid` output 1: result valid and held.
- `out_ready` input 1: downstream consumes the result.
- `dout_msb` output 6: accumulator bits [17:12].
- `dout_lsb` output 12: accumulator bits [11:0].
- `sat` output 1: sticky flag, set if any add in this run clamped.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states: IDLE, ACC, DONE.
- **IDLE**
  - `in_ready`=0, `dout_valid`=0.
  - On `start`: acc←sext18(`bias`), cnt←0, `sat`←0, go to ACC.
- **ACC**
  - `in_ready`=1.
  - A beat is accepted when `in_valid`=1: p = x·w, a 12-bit signed product, sign-extended.
  - Sum s = acc+p is computed at 19 bits and clamped to [−131072, +131071]. acc←clamped s. `sat`←1 if a clamp occurred.
  - cnt increments on each accepted beat. On the beat where cnt = N_INPUTS−1, go to DONE.
  - Cycles with `in_valid`=0 change nothing.
- **DONE**
  - `in_ready`=0, `dout_valid`=1.
  - `dout_msb`/`dout_lsb` = acc[17:12]/acc[11:0], held stable.
  - On `out_ready`=1, go to IDLE. acc and `sat` keep their values until the next `start`.
- `start` is ignored in ACC and DONE.
- Extreme product (−32)·(−32) = +1024 is representable and must be handled without wrap.
- Saturation applies per add. A later negative product may pull a clamped value back down, but the `sat` flag stays set for the rest of the run.

## Timing
- Reset (asynchronous, `rst_n`=0) forces:
  - state IDLE;
  - acc = 0, cnt = 0;
  - `sat` = 0, `busy` = 0, `in_ready` = 0, `dout_valid` = 0;
  - `dout_msb` = 0, `dout_lsb` = 0.
- Reset asserted mid-run aborts the run. No partial result is ever flagged valid.
- `start` at edge k puts the block in ACC from cycle k+1, so `in_ready` is first high in cycle k+1.
- Each accepted beat updates acc at the same edge it is accepted.
- The last beat accepted at edge m gives `dout_valid`=1 from cycle m+1. The result's latency is one cycle after the final beat.
- Back-to-back `in_valid` gives full throughput: one beat per cycle. A run takes N_INPUTS+1 cycles from `start` to `dout_valid` with no stalls.
- A DONE cycle with `out_ready`=1 returns to IDLE at the next edge. `dout_valid` drops that same edge.
- The earliest next `start` is sampled in the cycle after the handshake. Minimum cycles between successive results: N_INPUTS+2.
- `in_ready` and `dout_valid` are registered state decodes. Neither depends combinationally on `in_valid` or `out_ready`.

## Test plan
- **Basic:** N=8, bias=0, eight beats x=3, w=5 -> `dout_valid` one cycle after the 8th beat; {msb,lsb}=120; `sat`=0.
- **Negative with bias:** bias=−100, eight beats x=−4, w=7 -> result −324 = 18'h3FEBC; `dout_msb`=6'h3F, so it is negative for the ReLU.
- **Positive saturation:** N=255, bias=+2047, 255 beats x=−32, w=−32 -> result +131071 (18'h1FFFF); `sat`=1.
- **Negative saturation:** N=255, bias=−2048, 255 beats x=−32, w=31 -> result −131072 (18'h20000); `sat`=1.
- **Stalls and backpressure:** N=8, bias=0, x=2, w=3 on every beat, `in_valid` toggled randomly -> exactly 8 beats counted, result 48. Hold `out_ready`=0 for 5 cycles -> `dout_valid` and data remain stable until the handshake. A `start` pulsed during ACC/DONE is ignored.
- **Reset mid-run:** N=8, bias=0, x=1, w=1, drop `rst_n` after beat 4 -> all outputs 0 immediately. A new run with bias=10 and eight beats x=1, w=1 -> result 18, with no carry-over from the aborted run.

Source files
------------

// File: rtl/neuron_mac_acc_if.sv
// Handshake and data bundle between a neuron MAC stage and its neighbours.
// The master drives the operands and the result acknowledge.
// The slave (the MAC) drives the flow-control signals and the result.
interface neuron_mac_acc_if;
    logic        start;
    logic [11:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  x;
    logic [5:0]  w;
    logic        dout_valid;
    logic        out_ready;
    logic [5:0]  dout_msb;
    logic [11:0] dout_lsb;
    logic        sat;
    logic        busy;

    modport master (
        output start, bias, in_valid, x, w, out_ready,
        input  in_ready, dout_valid, dout_msb, dout_lsb, sat, busy
    );

    modport slave (
        input  start, bias, in_valid, x, w, out_ready,
        output in_ready, dout_valid, dout_msb, dout_lsb, sat, busy
    );
endinterface

// File: rtl/neuron_mac_acc.sv
// Serial multiply-accumulate stage for one neuron.
// Each accepted beat adds a signed 6x6 product into an 18-bit saturating
// accumulator seeded with a 12-bit bias. After N_INPUTS beats the result is
// held in DONE, split as msb/lsb for the downstream ReLU stage.
module neuron_mac_acc #(
    parameter int N_INPUTS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    neuron_mac_acc_if.slave       bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Beat counter is 8 bits wide, enough for the full 1..255 range of runs.
    localparam logic [7:0] LAST_BEAT = 8'(N_INPUTS - 1);

    logic [1:0]  state_q, state_d;
    logic [17:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sat_q, sat_d;

    logic [11:0] x_ext;
    logic [11:0] w_ext;
    logic [11:0] prod;
    logic [18:0] sum;
    logic [17:0] sum_clamped;
    logic        clamp_hit;

    // Product and saturating sum; a 12-bit product holds (-32)*(-32) without wrap.
    always_comb begin
        x_ext       = {{6{bus.x[5]}}, bus.x};
        w_ext       = {{6{bus.w[5]}}, bus.w};
        prod        = x_ext * w_ext;
        sum         = {acc_q[17], acc_q} + {{7{prod[11]}}, prod};
        sum_clamped = sum[17:0];
        clamp_hit   = 1'b0;
        if (!sum[18] && sum[17]) begin
            sum_clamped = 18'h1FFFF;
            clamp_hit   = 1'b1;
        end else if (sum[18] && !sum[17]) begin
            sum_clamped = 18'h20000;
            clamp_hit   = 1'b1;
        end
    end

    // Next-state logic for the IDLE -> ACC -> DONE run sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = {{6{bus.bias[11]}}, bus.bias};
                    cnt_d   = 8'd0;
                    sat_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (bus.in_valid) begin
                    acc_d = sum_clamped;
                    if (clamp_hit) begin
                        sat_d = 1'b1;
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run so no partial result is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 18'd0;
            cnt_q   <= 8'd0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Flow control is a pure decode of registered state, never of the handshakes.
    assign bus.in_ready   = (state_q == ST_ACC);
    assign bus.dout_valid = (state_q == ST_DONE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dout_msb   = acc_q[17:12];
    assign bus.dout_lsb   = acc_q[11:0];
    assign bus.sat        = sat_q;

endmodule
